// File: rtl/instr_encoder_if.sv
// ============================================================================
// Module : instr_encoder_if
// Brief  : Instruction handshake, memory-write and status bundle for instr_encoder
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic        pc_load;
  logic [63:0] pc_load_val;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        done;
  logic [3:0]  instr_len;
  logic [63:0] next_pc;
  logic        err;

  modport master (
    output in_valid, icode, ifun, rA, rB, valC, pc_load, pc_load_val,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, instr_len, next_pc, err
  );

  modport slave (
    input  in_valid, icode, ifun, rA, rB, valC, pc_load, pc_load_val,
    output in_ready, mem_we, mem_addr, mem_wdata, done, instr_len, next_pc, err
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module : instr_encoder
// Brief  : Byte-serial Y86-64 instruction encoder writing into instruction memory
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  instr_encoder_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] ptr_q, ptr_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  len_q, len_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  reg_q, reg_d;
  logic [63:0] valc_q, valc_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        done_q, done_d;
  logic [3:0]  ilen_q, ilen_d;
  logic        err_q, err_d;
  logic        w_ready;
  logic        w_accept;
  logic [3:0]  w_len;
  logic [63:0] w_start;

  // Zero length marks icodes C..F as invalid.
  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       len_of = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
      4'h7, 4'h8:             len_of = 4'd9;
      4'h3, 4'h4, 4'h5:       len_of = 4'd10;
      default:                len_of = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [3:0]  idx,
                                         input logic [7:0]  op,
                                         input logic [7:0]  regb,
                                         input logic [63:0] valc);
    logic       has_reg;
    logic [2:0] vidx;
    logic [63:0] sh;
    has_reg = (op[7:4] inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
    vidx    = 3'(idx - (has_reg ? 4'd2 : 4'd1));
    sh      = valc >> {vidx, 3'b000};
    if (idx == 4'd0)
      byte_at = op;
    else if (has_reg && idx == 4'd1)
      byte_at = regb;
    else
      byte_at = sh[7:0];
  endfunction

  assign w_ready  = (state_q == S_IDLE) && !rst;
  assign w_accept = bus.in_valid && w_ready;
  assign w_len    = len_of(bus.icode);
  assign w_start  = bus.pc_load ? bus.pc_load_val : ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    op_d    = op_q;
    reg_d   = reg_q;
    valc_d  = valc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    ilen_d  = ilen_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.pc_load)
          ptr_d = bus.pc_load_val;
        if (w_accept) begin
          if (w_len == 4'd0) begin
            err_d = 1'b1;
          end else begin
            // Byte 0 goes out on the accept edge, straight from the inputs.
            op_d    = {bus.icode, bus.ifun};
            valc_d  = bus.valC;
            len_d   = w_len;
            case (bus.icode)
              4'h3:       reg_d = {4'hF, bus.rB};
              4'hA, 4'hB: reg_d = {bus.rA, 4'hF};
              default:    reg_d = {bus.rA, bus.rB};
            endcase
            we_d    = 1'b1;
            addr_d  = w_start;
            wdata_d = {bus.icode, bus.ifun};
            ptr_d   = w_start + 64'd1;
            idx_d   = 4'd1;
            if (w_len == 4'd1) begin
              done_d = 1'b1;
              ilen_d = 4'd1;
            end
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (idx_q < len_q) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = byte_at(idx_q, op_q, reg_q, valc_q);
          ptr_d   = ptr_q + 64'd1;
          idx_d   = idx_q + 4'd1;
          if (idx_q == len_q - 4'd1) begin
            done_d = 1'b1;
            ilen_d = len_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE_ADDR;
      idx_q   <= 4'd0;
      len_q   <= 4'd0;
      op_q    <= 8'd0;
      reg_q   <= 8'd0;
      valc_q  <= 64'd0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 8'd0;
      done_q  <= 1'b0;
      ilen_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      valc_q  <= valc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ilen_q  <= ilen_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.done      = done_q;
  assign bus.instr_len = ilen_q;
  assign bus.next_pc   = ptr_q;
  assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module : tb_instr_encoder
// Brief  : Directed scoreboard bench for instr_encoder
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  data;
    logic        last;
    logic [3:0]  len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if bus();

  instr_encoder #(.BASE_ADDR(64'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [63:0] m_ptr = 64'd0;
  exp_t        sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoding; pushes up to lim bytes and returns the full length.
  function automatic int push_expected(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [63:0] vc, input int lim);
    logic [7:0] b[10];
    int         n;
    int         k;
    exp_t       e;
    n = 0;
    b[0] = {ic, fn};
    k = 1;
    case (ic)
      4'h0, 4'h1, 4'h9: n = 1;
      4'h2, 4'h6:       begin n = 2; b[1] = {ra, rb}; end
      4'hA, 4'hB:       begin n = 2; b[1] = {ra, 4'hF}; end
      4'h7, 4'h8:       n = 9;
      4'h3:             begin n = 10; b[1] = {4'hF, rb}; k = 2; end
      4'h4, 4'h5:       begin n = 10; b[1] = {ra, rb}; k = 2; end
      default:          n = 0;
    endcase
    if (n == 9 || n == 10)
      for (int i = 0; i < 8; i++) b[k + i] = vc[8*i +: 8];
    for (int i = 0; i < n && i < lim; i++) begin
      e.addr = m_ptr;
      e.data = b[i];
      e.last = (i == n - 1);
      e.len  = 4'(n);
      sb.push_back(e);
      m_ptr  = m_ptr + 64'd1;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_addr", bus.mem_addr, ~bus.mem_addr);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", 64'(bus.mem_wdata), 64'(e.data));
        chk("wr_done", 64'(bus.done), 64'(e.last));
        if (e.last) chk("instr_len", 64'(bus.instr_len), 64'(e.len));
      end
    end else begin
      chk("done_without_we", 64'(bus.done), 64'd0);
    end
  end

  // Called at a negedge with in_ready high; returns at the negedge it rises again.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, input logic ld,
                      input logic [63:0] ldv, input logic poke);
    int n;
    int cnt;
    chk("ready_before_send", 64'(bus.in_ready), 64'd1);
    if (ld) m_ptr = ldv;
    bus.icode = ic; bus.ifun = fn; bus.rA = ra; bus.rB = rb; bus.valC = vc;
    bus.pc_load = ld; bus.pc_load_val = ldv; bus.in_valid = 1'b1;
    n = push_expected(ic, fn, ra, rb, vc, 16);
    @(posedge clk);
    @(negedge clk);
    bus.pc_load = 1'b0;
    cnt = 0;
    while (bus.in_ready !== 1'b1 && cnt < 20) begin
      // Scrambled fields and a stray in_valid while busy must be ignored.
      bus.in_valid = 1'b1;
      bus.icode = 4'h1; bus.ifun = 4'($urandom); bus.rA = 4'($urandom);
      bus.rB = 4'($urandom); bus.valC = {$urandom, $urandom};
      bus.pc_load = poke && (cnt == 1);
      bus.pc_load_val = 64'h5555_0000_0000_5555;
      cnt++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.pc_load  = 1'b0;
    chk("ready_low_cycles", 64'(cnt), 64'(n));
    chk("next_pc", bus.next_pc, m_ptr);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.icode = 4'h0; bus.ifun = 4'h0; bus.rA = 4'h0; bus.rB = 4'h0;
    bus.valC = 64'd0; bus.pc_load = 1'b0; bus.pc_load_val = 64'd0;

    repeat (2) @(negedge clk);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_instr_len", 64'(bus.instr_len), 64'd0);
    chk("rst_next_pc", bus.next_pc, 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // irmovq: 30 F3 00 01 00.. at 0..9
    send(4'h3, 4'h0, 4'h0, 4'h3, 64'h100, 1'b0, 64'd0, 1'b0);

    // Short instructions back-to-back from address 0
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 1'b1, 64'd0, 1'b0);
    send(4'h2, 4'h0, 4'h2, 4'h5, 64'd0, 1'b0, 64'd0, 1'b0);
    send(4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 1'b0, 64'd0, 1'b0);
    chk("short_next_pc", bus.next_pc, 64'd5);

    // call at 0x40 with simultaneous pc_load, pc_load poked during EMIT
    send(4'h8, 4'h0, 4'hF, 4'hF, 64'h8, 1'b1, 64'h40, 1'b1);
    chk("call_next_pc", bus.next_pc, 64'h49);

    // Invalid icode
    bus.icode = 4'hC; bus.ifun = 4'h0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("inv_err", 64'(bus.err), 64'd1);
    chk("inv_in_ready", 64'(bus.in_ready), 64'd1);
    chk("inv_next_pc", bus.next_pc, 64'h49);
    @(negedge clk);
    chk("inv_err_pulse", 64'(bus.err), 64'd0);

    // Forced register fields and an mrmovq
    send(4'hA, 4'h0, 4'h3, 4'h0, 64'd0, 1'b0, 64'd0, 1'b0);
    send(4'hB, 4'h0, 4'h4, 4'h2, 64'd0, 1'b0, 64'd0, 1'b0);
    send(4'h5, 4'h0, 4'h7, 4'h1, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b0);

    // Wrap-around
    bus.pc_load = 1'b1; bus.pc_load_val = 64'hFFFF_FFFF_FFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    bus.pc_load = 1'b0;
    chk("load_next_pc", bus.next_pc, 64'hFFFF_FFFF_FFFF_FFFE);
    m_ptr = 64'hFFFF_FFFF_FFFF_FFFE;
    send(4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 1'b0, 64'd0, 1'b0);
    chk("wrap_next_pc", bus.next_pc, 64'd7);

    // Reset during byte 4 of rmmovq
    bus.icode = 4'h4; bus.ifun = 4'h0; bus.rA = 4'h1; bus.rB = 4'h2;
    bus.valC = 64'hAABB_CCDD_EEFF_0011; bus.in_valid = 1'b1;
    n = push_expected(4'h4, 4'h0, 4'h1, 4'h2, 64'hAABB_CCDD_EEFF_0011, 5);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_next_pc", bus.next_pc, 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_len", 64'(n), 64'd10);
    rst = 1'b0;
    m_ptr = 64'd0;
    @(negedge clk);
    chk("post_rst_sb", 64'(sb.size()), 64'd0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 64'd0, 1'b0);
    chk("nop_next_pc", bus.next_pc, 64'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
